prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/opcodes_pkg.sv | 22 ++
 rtl/prog_loader_pkg.sv | 30 +++
 rtl/opcode_check.sv | 26 ++
 rtl/prog_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/opcodes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : opcodes_pkg
// Description : Shared processor opcode set (6-bit opcode field, byte0[7:2])
// Revision    : 1.0 - initial release
// ============================================================================
package opcodes_pkg;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_ADDI = 6'h02;
  localparam logic [5:0] OP_SUB  = 6'h03;
  localparam logic [5:0] OP_SUBI = 6'h04;
  localparam logic [5:0] OP_MUL  = 6'h05;
  localparam logic [5:0] OP_MULI = 6'h06;
  localparam logic [5:0] OP_SHOW = 6'h07;
  localparam logic [5:0] OP_ADDS = 6'h08;
  localparam logic [5:0] OP_BREL = 6'h09;
  localparam logic [5:0] OP_BABS = 6'h0A;

endpackage
`default_nettype wire

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Loader state encoding, stream header byte and error codes
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_HDR  = 4'd1,
    ST_CNT  = 4'd2,
    ST_B0   = 4'd3,
    ST_B1   = 4'd4,
    ST_B2   = 4'd5,
    ST_WR   = 4'd6,
    ST_CSUM = 4'd7,
    ST_DONE = 4'd8,
    ST_ERR  = 4'd9
  } state_t;

  localparam logic [7:0] C_HDR_BYTE = 8'hA5;

  localparam logic [1:0] C_ERR_NONE = 2'b00;
  localparam logic [1:0] C_ERR_HDR  = 2'b01;
  localparam logic [1:0] C_ERR_OPC  = 2'b10;
  localparam logic [1:0] C_ERR_CSUM = 2'b11;

endpackage
`default_nettype wire

// File: rtl/opcode_check.sv
`default_nettype none
// ============================================================================
// Module      : opcode_check
// Description : Combinational legality check of a 6-bit opcode against the
//               shared processor opcode set
// Revision    : 1.0 - initial release
// ============================================================================
module opcode_check
  import opcodes_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       legal
);

  // Membership test against the shared opcode set
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_NOP, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL,
      OP_MULI, OP_SHOW, OP_ADDS, OP_BREL, OP_BABS: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Receives a framed program byte stream (header, count,
//               3-byte instructions, XOR checksum) and writes it into
//               program memory while holding the processor
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int INSTR_W = 24
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               pm_we,
  output logic [ADDR_W-1:0]  pm_addr,
  output logic [INSTR_W-1:0] pm_wdata,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err,
  output logic [1:0]         err_code
);

  localparam int C_DEPTH = 1 << ADDR_W;

  state_t              r_state;
  state_t              w_state_n;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     r_words;
  logic [ADDR_W:0]     w_words_inc;
  logic                w_last;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_xor;
  logic [7:0]          r_b0;
  logic [7:0]          r_b1;
  logic [INSTR_W-1:0]  r_wdata;
  logic                w_opc_legal;
  logic                w_clear;
  logic                w_set_err;
  logic [1:0]          w_err_code;
  logic                w_set_done;

  opcode_check u_opcode_check (
    .opcode (rx_data[7:2]),
    .legal  (w_opc_legal)
  );

  assign w_words_inc = r_words + 1'b1;
  assign w_last      = (w_words_inc == r_count);

  assign pm_we    = (r_state == ST_WR);
  assign pm_addr  = r_addr;
  assign pm_wdata = r_wdata;
  // Processor stays held through an error so it never runs a partial image
  assign cpu_hold = (r_state != ST_IDLE) && (r_state != ST_DONE);

  // State register, reset asynchronously to IDLE
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next-state decode, byte acceptance and status strobes
  always_comb begin
    w_state_n  = r_state;
    rx_ready   = 1'b0;
    w_clear    = 1'b0;
    w_set_err  = 1'b0;
    w_err_code = C_ERR_NONE;
    w_set_done = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          w_state_n = ST_HDR;
          w_clear   = 1'b1;
        end
      end
      ST_HDR: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (rx_data == C_HDR_BYTE) begin
            w_state_n = ST_CNT;
          end else begin
            w_state_n  = ST_ERR;
            w_set_err  = 1'b1;
            w_err_code = C_ERR_HDR;
          end
        end
      end
      ST_CNT: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if ((rx_data == 8'h00) || (int'(rx_data) > C_DEPTH)) begin
            w_state_n  = ST_ERR;
            w_set_err  = 1'b1;
            w_err_code = C_ERR_HDR;
          end else begin
            w_state_n = ST_B0;
          end
        end
      end
      ST_B0: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (w_opc_legal) begin
            w_state_n = ST_B1;
          end else begin
            w_state_n  = ST_ERR;
            w_set_err  = 1'b1;
            w_err_code = C_ERR_OPC;
          end
        end
      end
      ST_B1: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          w_state_n = ST_B2;
        end
      end
      ST_B2: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          w_state_n = ST_WR;
        end
      end
      ST_WR: begin
        w_state_n = w_last ? ST_CSUM : ST_B0;
      end
      ST_CSUM: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (rx_data == r_xor) begin
            w_state_n  = ST_DONE;
            w_set_done = 1'b1;
          end else begin
            w_state_n  = ST_ERR;
            w_set_err  = 1'b1;
            w_err_code = C_ERR_CSUM;
          end
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  // Datapath: status flags, word/address counters, byte assembly, running XOR
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      load_done <= 1'b0;
      load_err  <= 1'b0;
      err_code  <= C_ERR_NONE;
      r_count   <= '0;
      r_words   <= '0;
      r_addr    <= '0;
      r_xor     <= 8'h00;
      r_b0      <= 8'h00;
      r_b1      <= 8'h00;
      r_wdata   <= '0;
    end else begin
      if (w_clear) begin
        load_done <= 1'b0;
        load_err  <= 1'b0;
        err_code  <= C_ERR_NONE;
        r_words   <= '0;
        r_xor     <= 8'h00;
      end
      if (w_set_err) begin
        load_err <= 1'b1;
        err_code <= w_err_code;
      end
      if (w_set_done) begin
        load_done <= 1'b1;
      end
      case (r_state)
        ST_CNT: begin
          if (rx_valid && (w_state_n == ST_B0)) begin
            r_count <= (ADDR_W + 1)'(rx_data);
            r_addr  <= '0;
          end
        end
        ST_B0: begin
          if (rx_valid) begin
            r_b0  <= rx_data;
            r_xor <= r_xor ^ rx_data;
          end
        end
        ST_B1: begin
          if (rx_valid) begin
            r_b1  <= rx_data;
            r_xor <= r_xor ^ rx_data;
          end
        end
        ST_B2: begin
          if (rx_valid) begin
            r_wdata <= INSTR_W'({r_b0, r_b1, rx_data});
            r_xor   <= r_xor ^ rx_data;
          end
        end
        ST_WR: begin
          r_words <= w_words_inc;
          // Address stops at the last written word so a full image never wraps
          if (!w_last) begin
            r_addr <= r_addr + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
